// File: rtl/sqrt_arbiter_if.sv
// Bus bundle between the requester fabric, the sqrt_arbiter and the shared
// sqrt_core. Signal names carry the direction as seen from the arbiter.
// slave  : arbiter side
// master : fabric/core side (testbench)
interface sqrt_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid_i;
  logic [N_REQ*8-1:0] req_x_i;
  logic [N_REQ-1:0]   req_ready_o;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [ID_W-1:0]    rsp_id_o;
  logic [7:0]         rsp_r_o;
  logic               rsp_err_o;
  logic               core_enb_o;
  logic [7:0]         core_x_o;
  logic               core_busy_i;
  logic [7:0]         core_r_i;

  modport slave (
    input  req_valid_i, req_x_i, rsp_ready_i, core_busy_i, core_r_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_r_o, rsp_err_o,
           core_enb_o, core_x_o
  );

  modport master (
    output req_valid_i, req_x_i, rsp_ready_i, core_busy_i, core_r_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_r_o, rsp_err_o,
           core_enb_o, core_x_o
  );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin scheduler sharing one sqrt_core between N_REQ requesters.
// One request in flight at a time; result returned tagged with requester id.
// Optional watchdog abort enabled by defining SQRT_ARB_WDOG_EN.
//
// state | meaning
// IDLE  | arbitrate, accept one request (combinational ready strobe)
// START | pulse core enable with the registered operand
// WAIT  | enable follows core busy; capture result when busy drops
// RESP  | hold response until the consumer accepts it
module sqrt_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WDOG_CYC = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  sqrt_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      x_q, x_d;
  logic [7:0]      r_q, r_d;
`ifdef SQRT_ARB_WDOG_EN
  logic            err_q, err_d;
  logic [7:0]      cnt_q, cnt_d;
`endif

  logic            gnt_vld;
  logic [ID_W-1:0] gnt_id;
  logic [N_REQ-1:0] req_ready;
  logic            core_enb;
  logic            rsp_valid;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    // Scan from the farthest offset down so the nearest one wins last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (bus.req_valid_i[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx[ID_W-1:0];
      end
    end
  end

  // Next-state and output decode for the sequencing FSM.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    x_d       = x_q;
    r_d       = r_q;
`ifdef SQRT_ARB_WDOG_EN
    err_d     = err_q;
    cnt_d     = cnt_q;
`endif
    req_ready = '0;
    core_enb  = 1'b0;
    rsp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          req_ready[gnt_id] = 1'b1;
          id_d    = gnt_id;
          x_d     = bus.req_x_i[int'(gnt_id)*8 +: 8];
          state_d = START;
        end
      end
      START: begin
        core_enb = 1'b1;
`ifdef SQRT_ARB_WDOG_EN
        cnt_d    = '0;
`endif
        state_d  = WAIT;
      end
      WAIT: begin
        // Enable drops in the very cycle busy falls so the core cannot rerun.
        core_enb = bus.core_busy_i;
        if (!bus.core_busy_i) begin
          r_d     = bus.core_r_i;
`ifdef SQRT_ARB_WDOG_EN
          err_d   = 1'b0;
`endif
          state_d = RESP;
        end
`ifdef SQRT_ARB_WDOG_EN
        else if (cnt_q == 8'(WDOG_CYC)) begin
          core_enb = 1'b0;
          r_d      = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready_i) begin
          rr_ptr_d = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
`ifdef SQRT_ARB_WDOG_EN
          err_d    = 1'b0;
`endif
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      x_q      <= '0;
      r_q      <= '0;
`ifdef SQRT_ARB_WDOG_EN
      err_q    <= 1'b0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      x_q      <= x_d;
      r_q      <= r_d;
`ifdef SQRT_ARB_WDOG_EN
      err_q    <= err_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  // The ready strobe is combinational from the inputs, so mask it in reset.
  assign bus.req_ready_o = rst_i ? '0 : req_ready;
  assign bus.core_enb_o  = core_enb;
  assign bus.core_x_o    = x_q;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_id_o    = id_q;
  assign bus.rsp_r_o     = r_q;
`ifdef SQRT_ARB_WDOG_EN
  assign bus.rsp_err_o   = err_q;
`else
  assign bus.rsp_err_o   = 1'b0;
`endif

endmodule
